// File: rtl/moving_avg_filter.sv
// Boxcar moving-average filter: running window sum fed by a WIN-deep delay line,
// followed by a reciprocal-multiply mean with rounding and clamping.
module moving_avg_filter #(
   parameter int WIN    = 104,
   parameter int DW     = 12,
   parameter int SW     = 19,
   parameter int RSHIFT = 20,
   parameter int RECIP  = 10082
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in,
   input  logic [DW-1:0] in_dly,
   output logic [SW-1:0] sum_out,
   output logic [DW-1:0] mean_out,
   output logic          valid_out,
   output logic [6:0]    fill_cnt
);

   localparam int PW = SW + 14;
   localparam logic [6:0] WIN_C = 7'(WIN);

   typedef enum logic {FILL, RUN} state_t;

   state_t            state, state_nxt;
   logic [6:0]        cnt, cnt_nxt;
   logic              full_nxt;
   logic signed [SW:0] acc;
   logic [SW-1:0]     sum_p0;
   logic [PW-1:0]     prod_p1;
   logic [DW-1:0]     mean_p2;
   logic              vld_p0, vld_p1, vld_p2;

   function automatic logic [DW-1:0] round_sat(input logic [PW-1:0] p);
      logic [PW:0] q;
      q = ({1'b0, p} + (PW+1)'(2**(RSHIFT-1))) >> RSHIFT;
      if (q > (PW+1)'(2**DW - 1))
         round_sat = '1;
      else
         round_sat = DW'(q);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The full flag rises on the edge whose sample completes the window.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      full_nxt  = 1'b0;
      case (state)
         FILL: begin
            cnt_nxt = cnt + 7'd1;
            if (cnt_nxt == WIN_C) begin
               state_nxt = RUN;
               full_nxt  = 1'b1;
            end
         end
         RUN: full_nxt = 1'b1;
         default: state_nxt = FILL;
      endcase
   end

   // Wide signed accumulate; never negative while in_dly tracks in exactly.
   always_comb
      acc = $signed({1'b0, sum_p0})
          + $signed({{(SW+1-DW){1'b0}}, in})
          - $signed({{(SW+1-DW){1'b0}}, in_dly});

   // Stage 0: window sum
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_p0 <= '0;
         vld_p0 <= 1'b0;
      end else begin
         sum_p0 <= SW'(acc);
         vld_p0 <= full_nxt;
      end
   end

   // Stage 1: reciprocal scale
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         prod_p1 <= PW'(sum_p0) * PW'(RECIP);
         vld_p1  <= vld_p0;
      end
   end

   // Stage 2: round and clamp
   always_ff @(posedge clk) begin
      if (reset) begin
         mean_p2 <= '0;
         vld_p2  <= 1'b0;
      end else begin
         mean_p2 <= round_sat(prod_p1);
         vld_p2  <= vld_p1;
      end
   end

   assign sum_out   = sum_p0;
   assign mean_out  = mean_p2;
   assign valid_out = vld_p2;
   assign fill_cnt  = cnt;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Bench for moving_avg_filter: a behavioural delay line and window model drive
// and check every edge, plus directed scenarios with hand-computed constants.
module tb_moving_avg_filter;

   localparam int WIN = 104;
   localparam int DW  = 12;
   localparam int SW  = 19;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_s = '0;
   logic [DW-1:0] in_dly_s = '0;
   logic [SW-1:0] sum_out;
   logic [DW-1:0] mean_out;
   logic          valid_out;
   logic [6:0]    fill_cnt;

   moving_avg_filter dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_s),
      .in_dly    (in_dly_s),
      .sum_out   (sum_out),
      .mean_out  (mean_out),
      .valid_out (valid_out),
      .fill_cnt  (fill_cnt)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          k = 0;
   int unsigned win_q[$];
   longint      sum_hist[$];
   logic [31:0] e_sum, e_mean, e_fill;
   logic        e_vld;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, k, got, exp);
      end
   endtask

   // Mean defined as the rounded real quotient sum*RECIP/2^20, clamped to 12 bits.
   function automatic logic [31:0] ref_mean(input longint s);
      real r;
      r = $floor((real'(s) * 10082.0) / 1048576.0 + 0.5);
      if (r > 4095.0) r = 4095.0;
      return 32'($rtoi(r));
   endfunction

   task automatic step(input int unsigned x, input bit rst);
      longint s;
      in_s     = 12'(x);
      in_dly_s = (win_q.size() == WIN) ? 12'(win_q[0]) : '0;
      reset    = rst;
      @(posedge clk);
      #1;
      if (rst) begin
         win_q.delete();
         sum_hist.delete();
         k = 0;
         e_sum = 0; e_mean = 0; e_fill = 0; e_vld = 1'b0;
      end else begin
         k++;
         win_q.push_back(x);
         if (win_q.size() > WIN) void'(win_q.pop_front());
         s = 0;
         foreach (win_q[i]) s += win_q[i];
         sum_hist.push_back(s);
         if (sum_hist.size() > 3) void'(sum_hist.pop_front());
         e_sum  = 32'(s);
         e_mean = (sum_hist.size() == 3) ? ref_mean(sum_hist[0]) : 32'd0;
         e_fill = (k < WIN) ? 32'(k) : 32'(WIN);
         e_vld  = (k >= WIN + 2);
      end
      check_eq("sum_out", 32'(sum_out), e_sum);
      check_eq("mean_out", 32'(mean_out), e_mean);
      check_eq("valid_out", 32'(valid_out), 32'(e_vld));
      check_eq("fill_cnt", 32'(fill_cnt), e_fill);
   endtask

   initial begin
      int cnt_s, cnt_m;
      int unsigned xs[$];

      step(0, 1'b1);
      step(0, 1'b1);

      for (int i = 1; i <= 106; i++) begin
         step(1000, 1'b0);
         if (i == 104) check_eq("c1000_sum_e104", 32'(sum_out), 32'd104000);
         if (i == 105) check_eq("c1000_vld_e105", 32'(valid_out), 32'd0);
      end
      check_eq("c1000_vld_e106", 32'(valid_out), 32'd1);
      check_eq("c1000_mean", 32'(mean_out), 32'd1000);
      check_eq("c1000_fill", 32'(fill_cnt), 32'd104);

      for (int i = 0; i < 110; i++) step(4095, 1'b0);
      check_eq("max_sum", 32'(sum_out), 32'd425880);
      check_eq("max_mean", 32'(mean_out), 32'd4095);
      for (int i = 0; i < 110; i++) step(0, 1'b0);
      check_eq("drain_sum", 32'(sum_out), 32'd0);
      check_eq("drain_mean", 32'(mean_out), 32'd0);

      cnt_s = 0; cnt_m = 0;
      step(4095, 1'b0);
      if (sum_out == 19'd4095) cnt_s++;
      for (int i = 0; i < 110; i++) begin
         step(0, 1'b0);
         if (sum_out == 19'd4095) cnt_s++;
         if (mean_out == 12'd39) cnt_m++;
      end
      check_eq("impulse_sum_span", 32'(cnt_s), 32'd104);
      check_eq("impulse_mean_span", 32'(cnt_m), 32'd104);

      for (int i = 0; i < 110; i++) begin
         step(2000, 1'b0);
         if (i == 51) check_eq("step_sum_s51", 32'(sum_out), 32'd104000);
         if (i == 53) check_eq("step_mean_s53", 32'(mean_out), 32'd1000);
      end
      check_eq("step_mean_final", 32'(mean_out), 32'd2000);

      step(500, 1'b1);
      check_eq("rst_sum", 32'(sum_out), 32'd0);
      check_eq("rst_fill", 32'(fill_cnt), 32'd0);
      for (int i = 1; i <= 106; i++) begin
         step(500, 1'b0);
         if (i == 105) check_eq("r500_vld_e105", 32'(valid_out), 32'd0);
      end
      check_eq("r500_vld_e106", 32'(valid_out), 32'd1);
      check_eq("r500_mean", 32'(mean_out), 32'd500);

      xs = '{0, 1, 2, 1023, 2047, 2048, 3000, 4094, 4095};
      for (int i = 0; i < 25; i++) xs.push_back($urandom_range(0, 4095));
      foreach (xs[j]) begin
         for (int i = 0; i < 106; i++) step(xs[j], 1'b0);
         check_eq("sweep_mean", 32'(mean_out), 32'(xs[j]));
         check_eq("sweep_sum", 32'(sum_out), 32'(xs[j] * 104));
      end

      for (int i = 0; i < 600; i++) begin
         int unsigned x;
         case ($urandom_range(0, 3))
            0: x = 0;
            1: x = 4095;
            default: x = $urandom_range(0, 4095);
         endcase
         step(x, ($urandom_range(0, 249) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
